// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler: read FSM states,
// a constant log2 helper and default geometry.
package fft_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_GAP    = 2'd2
   } rd_state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   localparam int unsigned N_DEFAULT     = 64;
   localparam int unsigned WIDTH_DEFAULT = 16;
   localparam int unsigned LOG_N_DEFAULT = clog2(N_DEFAULT);

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank frame store: simple dual-port RAM, bank+address on both ports,
// registered read data with one cycle of latency. The array is not reset.
module frame_pingpong_buf
   import fft_sched_pkg::*;
#(
   parameter int unsigned LOG_N = LOG_N_DEFAULT,
   parameter int unsigned DW    = 2 * WIDTH_DEFAULT
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic             wr_bank,
   input  logic [LOG_N-1:0] wr_addr,
   input  logic [DW-1:0]    wr_data,
   input  logic             rd_en,
   input  logic             rd_bank,
   input  logic [LOG_N-1:0] rd_addr,
   output logic [DW-1:0]    rd_data
);

   localparam int unsigned DEPTH = 2 * (1 << LOG_N);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[{wr_bank, wr_addr}] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[{rd_bank, rd_addr}];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_scheduler.sv
// Front-end sequencer for the SDF FFT chain: ping-pong frame capture, gap-free
// frame replay, in-flight accounting. Define FFT_FRAME_GAP_EN for inter-frame gaps.
module fft_frame_scheduler
   import fft_sched_pkg::*;
#(
   parameter int unsigned N            = N_DEFAULT,
   parameter int unsigned WIDTH        = WIDTH_DEFAULT,
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter int unsigned GAP          = 1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [WIDTH-1:0]               s_data_r,
   input  logic [WIDTH-1:0]               s_data_i,
   output logic                           fft_en,
   output logic [WIDTH-1:0]               fft_data_r,
   output logic [WIDTH-1:0]               fft_data_i,
   input  logic                           fft_oen,
   output logic                           frame_done,
   output logic [clog2(MAX_INFLIGHT):0]   inflight,
   output logic                           busy,
   output logic                           err_unexp
);

   localparam int unsigned LOG_N = clog2(N);
   localparam int unsigned IF_W  = clog2(MAX_INFLIGHT) + 1;
   localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

   logic [1:0]       full_q, full_d, set_full, clr_full;
   logic             wr_bank_q, wr_bank_d, wr_fire;
   logic [LOG_N-1:0] wr_addr_q, wr_addr_d;
   rd_state_e        state_q, state_d;
   logic             rd_bank_q, rd_bank_d, rd_en, next_ready;
   logic [LOG_N-1:0] rd_addr_q, rd_addr_d;
   logic             fft_en_q, first_q, first_d;
   logic [IF_W-1:0]  inflight_q, inflight_d;
   logic [LOG_N-1:0] out_cnt_q, out_cnt_d;
   logic             frame_done_q, frame_done_d, err_q, err_d, busy_q, busy_d;
   logic [2*WIDTH-1:0] rd_data;
`ifdef FFT_FRAME_GAP_EN
   logic [7:0]       gap_cnt_q, gap_cnt_d;
`endif

   assign s_ready = !full_q[wr_bank_q];
   assign wr_fire = s_valid && s_ready;

   always_comb begin
      wr_addr_d = wr_addr_q;
      wr_bank_d = wr_bank_q;
      set_full  = 2'b00;
      if (wr_fire) begin
         wr_addr_d = wr_addr_q + 1'b1;
         if (wr_addr_q == LAST) begin
            set_full[wr_bank_q] = 1'b1;
            wr_bank_d           = !wr_bank_q;
         end
      end
   end

   // A bank completing on this very edge counts as ready so back-to-back
   // frames chain without a bubble.
   assign next_ready = full_q[!rd_bank_q] || set_full[!rd_bank_q];

   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      rd_bank_d = rd_bank_q;
      rd_en     = 1'b0;
      clr_full  = 2'b00;
`ifdef FFT_FRAME_GAP_EN
      gap_cnt_d = gap_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (full_q[rd_bank_q] && inflight_q < IF_W'(MAX_INFLIGHT)) begin
               state_d   = ST_STREAM;
               rd_addr_d = '0;
            end
         end
         ST_STREAM: begin
            rd_en     = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == LAST) begin
               clr_full[rd_bank_q] = 1'b1;
               rd_bank_d           = !rd_bank_q;
`ifdef FFT_FRAME_GAP_EN
               state_d   = ST_GAP;
               gap_cnt_d = 8'(GAP - 1);
`else
               if (!(next_ready && inflight_q < IF_W'(MAX_INFLIGHT - 1))) state_d = ST_IDLE;
`endif
            end
         end
`ifdef FFT_FRAME_GAP_EN
         // The final gap cycle doubles as the idle decision so the bubble is exactly GAP.
         ST_GAP: begin
            if (gap_cnt_q == 8'd0) begin
               state_d   = ST_IDLE;
               if (full_q[rd_bank_q] && inflight_q < IF_W'(MAX_INFLIGHT)) begin
                  state_d   = ST_STREAM;
                  rd_addr_d = '0;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   assign full_d  = (full_q | set_full) & ~clr_full;
   assign first_d = rd_en && (rd_addr_q == '0);

   always_comb begin
      out_cnt_d    = out_cnt_q;
      frame_done_d = 1'b0;
      err_d        = err_q;
      if (fft_oen) begin
         if (inflight_q == '0 && out_cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            out_cnt_d = out_cnt_q + 1'b1;
            if (out_cnt_q == LAST) frame_done_d = 1'b1;
         end
      end
      inflight_d = inflight_q + IF_W'(first_q);
      if (frame_done_q && inflight_q != '0) inflight_d = inflight_d - IF_W'(1);
      busy_d = (|full_q) || (state_q != ST_IDLE) || (inflight_q != '0);
   end

   frame_pingpong_buf #(.LOG_N(LOG_N), .DW(2 * WIDTH)) u_buf (
      .clock   (clock),
      .wr_en   (wr_fire),
      .wr_bank (wr_bank_q),
      .wr_addr (wr_addr_q),
      .wr_data ({s_data_r, s_data_i}),
      .rd_en   (rd_en),
      .rd_bank (rd_bank_q),
      .rd_addr (rd_addr_q),
      .rd_data (rd_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         full_q       <= '0;
         wr_bank_q    <= 1'b0;
         wr_addr_q    <= '0;
         state_q      <= ST_IDLE;
         rd_bank_q    <= 1'b0;
         rd_addr_q    <= '0;
         fft_en_q     <= 1'b0;
         first_q      <= 1'b0;
         inflight_q   <= '0;
         out_cnt_q    <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
`ifdef FFT_FRAME_GAP_EN
         gap_cnt_q    <= '0;
`endif
      end else begin
         full_q       <= full_d;
         wr_bank_q    <= wr_bank_d;
         wr_addr_q    <= wr_addr_d;
         state_q      <= state_d;
         rd_bank_q    <= rd_bank_d;
         rd_addr_q    <= rd_addr_d;
         fft_en_q     <= rd_en;
         first_q      <= first_d;
         inflight_q   <= inflight_d;
         out_cnt_q    <= out_cnt_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
`ifdef FFT_FRAME_GAP_EN
         gap_cnt_q    <= gap_cnt_d;
`endif
      end
   end

   assign fft_en     = fft_en_q;
   assign fft_data_r = fft_en_q ? rd_data[2*WIDTH-1:WIDTH] : '0;
   assign fft_data_i = fft_en_q ? rd_data[WIDTH-1:0] : '0;
   assign frame_done = frame_done_q;
   assign inflight   = inflight_q;
   assign busy       = busy_q;
   assign err_unexp  = err_q;

endmodule

// File: doc/fft_frame_scheduler.md
Name: fft_frame_scheduler

Overview:
- Front-end sequencer for the radix-2^2 SDF FFT pipeline chain.
- Accepts complex samples on a valid/ready stream and collects them into a ping-pong frame buffer of 2 x N entries.
- Replays each complete frame to the first SDF stage as exactly N contiguous enabled cycles, which is what the stage counters require.
- Counts returned samples from the last stage to produce per-frame completion pulses and error flags.

Parameters:
- N, 64, FFT points per frame; power of two, >= 4.
- WIDTH, 16, bit length of each real/imag sample.
- MAX_INFLIGHT, 4, maximum frames issued to the pipeline but not yet returned; power of two, >= 2.
- GAP, 1, idle cycles inserted between frames; used only when FFT_FRAME_GAP_EN is defined; range 1..255.

Ports:
- clock  in  1  master clock
- reset  in  1  active-high asynchronous reset
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler can accept a sample
- s_data_r  in  WIDTH  input sample, real
- s_data_i  in  WIDTH  input sample, imag
- fft_en  out  1  data enable to first SDF stage
- fft_data_r  out  WIDTH  sample to first stage, real
- fft_data_i  out  WIDTH  sample to first stage, imag
- fft_oen  in  1  output data enable from last SDF stage
- frame_done  out  1  one-cycle pulse on the N-th returned sample of a frame
- inflight  out  log2(MAX_INFLIGHT)+1  frames issued but not yet returned
- busy  out  1  any bank full, streaming, or inflight != 0
- err_unexp  out  1  sticky: fft_oen seen while inflight == 0

Behaviour:
- One clock domain: clock. Reset is asynchronous and active-high.
- Reset clears all state:
  - s_ready=1, fft_en=0, fft_data=0, frame_done=0, inflight=0, busy=0, err_unexp=0.
  - full[1:0]=0, wr_bank=0, rd_bank=0, all address counters=0, FSM=IDLE.
- Reset mid-operation discards buffered and in-flight frames. No partial frame is replayed.
- Write side:
  - s_ready = !full[wr_bank].
  - Each transfer (s_valid & s_ready) writes to bank wr_bank at wr_addr, then wr_addr++.
  - On the write with wr_addr == N-1: set full[wr_bank], toggle wr_bank, wrap wr_addr to 0.
- Read FSM states: IDLE, STREAM, GAP.
  - IDLE -> STREAM when full[rd_bank] && inflight < MAX_INFLIGHT. rd_addr=0.
  - STREAM: issue read address rd_addr each cycle, rd_addr++.
  - When rd_addr == N-1 is issued: clear full[rd_bank] next edge, toggle rd_bank.
  - Then, if full[other bank] && inflight+1 < MAX_INFLIGHT, stay in STREAM with rd_addr=0 (back-to-back frames, no bubble). Otherwise go to IDLE (GAP when the macro is defined).
- Buffer read latency is 1 cycle. fft_en and fft_data are registered and lag the issued address by exactly 1 cycle.
- A frame therefore appears as exactly N consecutive cycles of fft_en=1. fft_en never drops mid-frame.
- fft_data is driven to 0 when fft_en=0.
- Simultaneous events:
  - Write setting full on one bank while read clears the other: both apply.
  - The same bank cannot be set and cleared in one cycle; the write side is blocked while its bank is full.
- inflight:
  - +1 on the first fft_en cycle of a frame.
  - -1 on frame_done.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_INFLIGHT, because issue is gated.
- Return side:
  - out_cnt (log2 N bits) increments on each fft_oen.
  - At out_cnt == N-1 with fft_oen: frame_done=1 for one cycle (registered, 1 cycle after that fft_oen), and out_cnt wraps to 0.
  - fft_oen with inflight == 0 and out_cnt == 0: set err_unexp (sticky until reset); the sample is not counted.
- busy is a registered OR of full[0], full[1], FSM != IDLE, and inflight != 0.

Optional Feature:
- FFT_FRAME_GAP_EN defined:
  - After each frame's last read, FSM enters GAP for GAP cycles with fft_en=0, then IDLE.
  - Back-to-back streaming is disabled.
  - The write side is unaffected.
- Not defined:
  - GAP state and its counter are not synthesized.
  - Frames stream back-to-back when available.

Decomposition:
- Package fft_sched_pkg:
  - read FSM state enum (IDLE/STREAM/GAP)
  - log2 constant function
  - LOG_N-derived width constants
- Sub-module frame_pingpong_buf: 2*N x 2*WIDTH simple dual-port RAM.
  - Write port: bank and address.
  - Registered read port with 1-cycle latency.
  - No reset on the array.

Test Plan:
- N=64, continuous s_valid with a ramp 0..63, fft_oen looped back from fft_en through a 10-cycle delay:
  - fft_en high for exactly 64 cycles, starting 2 cycles after the 64th accept.
  - fft_data_r = 0..63 in order.
  - frame_done pulses once.
  - inflight returns to 0.
- Three frames pushed continuously without the macro:
  - fft_en stays high for 192 consecutive cycles.
  - s_ready drops only while both banks are full.
- Loopback removed (fft_oen=0), MAX_INFLIGHT=4, 6 frames pushed:
  - Exactly 4 frames issued; inflight=4.
  - s_ready=0 after both banks fill.
  - busy=1 throughout.
- fft_oen pulsed for 1 cycle after reset with nothing issued:
  - err_unexp=1 and stays set.
  - out_cnt unchanged; frame_done never pulses.
- Reset asserted at sample 30 of a streaming frame:
  - fft_en=0 and s_ready=1 asynchronously.
  - After release, the next 64 pushed samples produce one clean frame.
- FFT_FRAME_GAP_EN with GAP=3, two frames queued:
  - Exactly 3 cycles of fft_en=0 between the two 64-cycle bursts.
